// File: rtl/uop_dispatch_queue.sv
// uop_dispatch_queue: in-order queue between rename and the issue queues.
// Takes up to FETCH_WIDTH renamed ops per cycle and hands them out in order
// onto ALU_PORTS ALU channels, one MEM channel and one TERM channel, with
// per-channel backpressure. A dispatched terminator halts dispatch until a
// wakeup pulse arrives.
// Optional build macro DISPATCH_STATS_EN adds the stat_dispatched and
// stat_stall counters.
module uop_dispatch_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int OP_W        = 47,
    parameter int DEPTH       = 16,
    parameter int ALU_PORTS   = 2,
    parameter int ISSUE_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wakeup,
    input  logic                          flush,
    input  logic [FETCH_WIDTH*OP_W-1:0]   in_ops,
    input  logic [FETCH_WIDTH-1:0]        in_valid,
    output logic                          in_ready,
    output logic [ALU_PORTS*OP_W-1:0]     alu_ops,
    output logic [ALU_PORTS-1:0]          alu_valid,
    input  logic [ALU_PORTS-1:0]          alu_ready,
    output logic [OP_W-1:0]               mem_op,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic [OP_W-1:0]               term_op,
    output logic                          term_valid,
    input  logic                          term_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          running
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                   stat_dispatched,
    output logic [31:0]                   stat_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IW_W  = $clog2(ISSUE_WIDTH + 1);
    localparam logic [FETCH_WIDTH-1:0] ONE_LANE = FETCH_WIDTH'(1);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    logic [OP_W-1:0]  entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, enq_n;
    state_t           state_q, state_d;
    logic             enq_fire;
    logic [IW_W-1:0]  n_grant;
    logic             term_grant;
    logic             walk_on;
    logic             granted;
    logic [2:0]       op_cls;
    logic [OP_W-1:0]  win_op  [ISSUE_WIDTH];
    logic             win_occ [ISSUE_WIDTH];

    assign in_ready = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign enq_fire = in_valid[0] && in_ready && !flush;
    assign count    = count_q;

    // Dispatch window: the oldest ISSUE_WIDTH slots and whether each is occupied.
    generate
        for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_win
            assign win_op[gi]  = entries_q[head_q + PTR_W'(gi)];
            assign win_occ[gi] = (count_q > CNT_W'(gi));
        end
    endgenerate

    // Number of lanes offered this cycle (in_valid is a prefix, so a popcount).
    always_comb begin
        enq_n = '0;
        for (int g = 0; g < FETCH_WIDTH; g++) begin
            enq_n = enq_n + CNT_W'(in_valid[g]);
        end
    end

    // In-order walk over the window; stops at the first op that cannot go.
    always_comb begin
        alu_valid  = '0;
        alu_ops    = '0;
        mem_valid  = 1'b0;
        mem_op     = '0;
        term_valid = 1'b0;
        term_op    = '0;
        n_grant    = '0;
        term_grant = 1'b0;
        granted    = 1'b0;
        op_cls     = '0;
        walk_on    = (state_q == S_RUN);
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            op_cls  = win_op[i][OP_W-1 -: 3];
            granted = 1'b0;
            if (walk_on && win_occ[i]) begin
                if (op_cls == 3'b111) begin
                    if (term_ready) begin
                        term_valid = 1'b1;
                        term_op    = win_op[i];
                        granted    = 1'b1;
                        term_grant = 1'b1;
                    end
                end else if (op_cls[2]) begin
                    if (!mem_valid && mem_ready) begin
                        mem_valid = 1'b1;
                        mem_op    = win_op[i];
                        granted   = 1'b1;
                    end
                end else begin
                    for (int k = 0; k < ALU_PORTS; k++) begin
                        if (!granted && !alu_valid[k] && alu_ready[k]) begin
                            alu_valid[k]              = 1'b1;
                            alu_ops[k*OP_W +: OP_W]   = win_op[i];
                            granted                   = 1'b1;
                        end
                    end
                end
            end
            if (granted) begin
                n_grant = n_grant + IW_W'(1);
            end
            walk_on = walk_on && granted && !term_grant;
        end
    end

    // Pointer and occupancy update; flush wins over a same-cycle enqueue.
    always_comb begin
        head_d  = head_q + PTR_W'(n_grant);
        tail_d  = tail_q;
        count_d = count_q - CNT_W'(n_grant);
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else if (enq_fire) begin
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_d + enq_n;
        end
    end

    // Queue storage: valid lanes land at tail in lane order.
    always_ff @(posedge clk) begin
        for (int g = 0; g < FETCH_WIDTH; g++) begin
            if (enq_fire && in_valid[g]) begin
                entries_q[tail_q + PTR_W'(g)] <= in_ops[g*OP_W +: OP_W];
            end
        end
    end

    // Pointer, count and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= S_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Next state: a granted terminator halts; wakeup only matters while halted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (term_grant) state_d = S_HALT;
            S_HALT:  if (wakeup)     state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // State-derived output.
    always_comb begin
        running = (state_q == S_RUN);
    end

    // in_valid must be a contiguous run starting at lane 0.
    assert property (@(posedge clk) disable iff (rst)
        ((in_valid & (in_valid + ONE_LANE)) == '0));

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_disp_q, stat_disp_d, stat_stall_q, stat_stall_d;
    logic [32:0] disp_sum;

    // Saturating statistics; flush clears them like reset.
    always_comb begin
        disp_sum     = {1'b0, stat_disp_q} + 33'(n_grant);
        stat_disp_d  = disp_sum[32] ? 32'hFFFF_FFFF : disp_sum[31:0];
        stat_stall_d = stat_stall_q;
        if (state_q == S_RUN && count_q != '0 && n_grant == '0
            && stat_stall_q != 32'hFFFF_FFFF) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
        if (flush) begin
            stat_disp_d  = '0;
            stat_stall_d = '0;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_disp_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_disp_q  <= stat_disp_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_dispatched = stat_disp_q;
    assign stat_stall      = stat_stall_q;
`endif

endmodule

// File: tb/tb_uop_dispatch_queue.sv
// Testbench for uop_dispatch_queue: table-driven directed cycles, hand-written
// corner sequences and a randomized run, all shadowed by a queue-based model.
module tb_uop_dispatch_queue;

    localparam logic [2:0] TA = 3'b000;
    localparam logic [2:0] TM = 3'b100;
    localparam logic [2:0] TT = 3'b111;

    logic           clk = 1'b0;
    logic           rst, wakeup, flush;
    logic [187:0]   in_ops;
    logic [3:0]     in_valid;
    logic           in_ready;
    logic [93:0]    alu_ops;
    logic [1:0]     alu_valid, alu_ready;
    logic [46:0]    mem_op, term_op;
    logic           mem_valid, mem_ready, term_valid, term_ready;
    logic [4:0]     count;
    logic           running;
`ifdef DISPATCH_STATS_EN
    logic [31:0]    stat_dispatched, stat_stall;
`endif

    uop_dispatch_queue dut (
        .clk(clk), .rst(rst), .wakeup(wakeup), .flush(flush),
        .in_ops(in_ops), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ops(alu_ops), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .mem_op(mem_op), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .term_op(term_op), .term_valid(term_valid), .term_ready(term_ready),
        .count(count), .running(running)
`ifdef DISPATCH_STATS_EN
        , .stat_dispatched(stat_dispatched), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [43:0] seq      = '0;

    // Reference model: a plain FIFO of ops plus a run flag.
    logic [46:0] mq[$];
    bit          run_m = 1'b1;
    longint      s_disp = 0, s_stall = 0;
    int          last_obs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load(input int nv, input logic [11:0] types);
        in_valid = '0;
        for (int g = 0; g < 4; g++) begin
            if (g < nv) begin
                in_valid[g] = 1'b1;
                in_ops[g*47 +: 47] = {types[g*3 +: 3], seq};
                seq = seq + 44'd1;
            end else begin
                in_ops[g*47 +: 47] = 47'({$urandom(), $urandom()});
            end
        end
    endtask

    // One clock cycle: predict, compare, clock, advance the model.
    task automatic step();
        logic [46:0] e_alu [2];
        logic [1:0]  e_av;
        logic        e_mv, e_tv, termg, placed;
        logic [46:0] e_mop, e_top, op;
        logic [2:0]  t;
        int          n, s0, nv;
        e_av = '0; e_mv = 0; e_tv = 0; termg = 0; n = 0;
        e_alu[0] = '0; e_alu[1] = '0; e_mop = '0; e_top = '0;
        s0 = mq.size();
        if (run_m) begin
            for (int i = 0; i < 4 && i < s0; i++) begin
                op = mq[i];
                t  = op[46:44];
                if (t == TT) begin
                    if (!term_ready) break;
                    e_tv = 1; e_top = op; n++; termg = 1;
                    break;
                end else if (t[2]) begin
                    if (e_mv || !mem_ready) break;
                    e_mv = 1; e_mop = op; n++;
                end else begin
                    placed = 0;
                    for (int k = 0; k < 2; k++) begin
                        if (!placed && !e_av[k] && alu_ready[k]) begin
                            e_av[k] = 1; e_alu[k] = op; placed = 1;
                        end
                    end
                    if (!placed) break;
                    n++;
                end
            end
        end
        #1;
        chk("count", 64'(count), 64'(s0));
        chk("running", 64'(running), 64'(run_m));
        chk("in_ready", 64'(in_ready), 64'(s0 <= 12));
        chk("alu_valid", 64'(alu_valid), 64'(e_av));
        chk("mem_valid", 64'(mem_valid), 64'(e_mv));
        chk("term_valid", 64'(term_valid), 64'(e_tv));
        if (e_av[0]) chk("alu_op0", 64'(alu_ops[46:0]), 64'(e_alu[0]));
        if (e_av[1]) chk("alu_op1", 64'(alu_ops[93:47]), 64'(e_alu[1]));
        if (e_mv)    chk("mem_op", 64'(mem_op), 64'(e_mop));
        if (e_tv)    chk("term_op", 64'(term_op), 64'(e_top));
`ifdef DISPATCH_STATS_EN
        chk("stat_dispatched", 64'(stat_dispatched), 64'(s_disp));
        chk("stat_stall", 64'(stat_stall), 64'(s_stall));
`endif
        last_obs = int'(alu_valid[0]) + int'(alu_valid[1]) + int'(mem_valid) + int'(term_valid);
        @(posedge clk);
        if (rst) begin
            mq.delete(); run_m = 1; s_disp = 0; s_stall = 0;
        end else begin
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            s_disp = s_disp + n;
            if (s_disp > 64'hFFFF_FFFF) s_disp = 64'hFFFF_FFFF;
            if (run_m && s0 > 0 && n == 0 && s_stall < 64'hFFFF_FFFF) s_stall++;
            if (flush) begin
                mq.delete(); s_disp = 0; s_stall = 0;
            end else if (in_valid[0] && s0 <= 12) begin
                nv = 0;
                for (int g = 0; g < 4; g++) if (in_valid[g]) nv++;
                for (int g = 0; g < nv; g++) mq.push_back(in_ops[g*47 +: 47]);
            end
            if (run_m && termg) run_m = 0;
            else if (!run_m && wakeup) run_m = 1;
        end
        @(negedge clk);
    endtask

    task automatic set_ready(input logic [1:0] ar, input logic mr, input logic tr);
        alu_ready = ar; mem_ready = mr; term_ready = tr;
    endtask

    // Empty the queue with every sink ready, waking from HALT as needed.
    task automatic drain();
        int guard = 0;
        set_ready(2'b11, 1, 1); flush = 0;
        while ((mq.size() > 0 || !run_m) && guard < 80) begin
            load(0, '0);
            wakeup = !run_m;
            step();
            guard++;
        end
        wakeup = 0;
        chk("drain_bound", 64'(guard < 80), 64'd1);
    endtask

    typedef struct {
        int          nv;
        logic [11:0] types;
        logic [1:0]  ar;
        logic        mr, tr, wk;
        logic [1:0]  e_av;
        logic        e_mv, e_tv;
        int          e_cnt;
        logic        e_run, e_ir;
    } vec_t;

    vec_t vt[8];

    initial begin
        int total, pushed, guard;
        logic [2:0] rt;
        logic [11:0] rtypes;

        vt[0] = '{4, {TA, TA, TA, TA}, 2'b11, 1, 1, 0, 2'b00, 0, 0, 0, 1, 1};
        vt[1] = '{0, 12'h000,          2'b11, 1, 1, 0, 2'b11, 0, 0, 4, 1, 1};
        vt[2] = '{0, 12'h000,          2'b11, 1, 1, 0, 2'b11, 0, 0, 2, 1, 1};
        vt[3] = '{0, 12'h000,          2'b11, 1, 1, 0, 2'b00, 0, 0, 0, 1, 1};
        vt[4] = '{4, {TT, TA, TM, TA}, 2'b11, 1, 1, 0, 2'b00, 0, 0, 0, 1, 1};
        vt[5] = '{0, 12'h000,          2'b11, 1, 1, 0, 2'b11, 1, 1, 4, 1, 1};
        vt[6] = '{0, 12'h000,          2'b11, 1, 1, 1, 2'b00, 0, 0, 0, 0, 1};
        vt[7] = '{0, 12'h000,          2'b11, 1, 1, 0, 2'b00, 0, 0, 0, 1, 1};

        rst = 1; wakeup = 0; flush = 0; in_ops = '0; in_valid = '0;
        set_ready(2'b11, 1, 1);
        @(negedge clk);
        step(); step();
        rst = 0;
        #1;
        chk("reset.count", 64'(count), 64'd0);
        chk("reset.running", 64'(running), 64'd1);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.valids", 64'({alu_valid, mem_valid, term_valid}), 64'd0);
        @(negedge clk);

        // Directed cycles from the table.
        for (int r = 0; r < 8; r++) begin
            load(vt[r].nv, vt[r].types);
            set_ready(vt[r].ar, vt[r].mr, vt[r].tr);
            wakeup = vt[r].wk;
            #1;
            chk($sformatf("vec%0d.alu_valid", r), 64'(alu_valid), 64'(vt[r].e_av));
            chk($sformatf("vec%0d.mem_valid", r), 64'(mem_valid), 64'(vt[r].e_mv));
            chk($sformatf("vec%0d.term_valid", r), 64'(term_valid), 64'(vt[r].e_tv));
            chk($sformatf("vec%0d.count", r), 64'(count), 64'(vt[r].e_cnt));
            chk($sformatf("vec%0d.running", r), 64'(running), 64'(vt[r].e_run));
            chk($sformatf("vec%0d.in_ready", r), 64'(in_ready), 64'(vt[r].e_ir));
            step();
        end
        wakeup = 0;

        // Fill to DEPTH behind a blocked MEM head.
        set_ready(2'b11, 0, 1);
        load(4, {TA, TA, TA, TM}); step();
        for (int i = 0; i < 3; i++) begin
            load(4, {TA, TA, TA, TA}); step();
        end
        load(4, {TA, TA, TA, TA});
        #1;
        chk("full.count", 64'(count), 64'd16);
        chk("full.in_ready", 64'(in_ready), 64'd0);
        chk("full.valids", 64'({alu_valid, mem_valid, term_valid}), 64'd0);
        step();
        load(0, '0);
        mem_ready = 1;
        #1;
        chk("unblock.mem_valid", 64'(mem_valid), 64'd1);
        chk("unblock.alu_valid", 64'(alu_valid), 64'b11);
        step();
        drain();

        // 40 ops two lanes at a time across pointer wrap, random sinks.
        total = 0; pushed = 0; guard = 0;
        while (pushed < 40 && guard < 500) begin
            set_ready(2'($urandom), 1'($urandom), 1);
            if (mq.size() <= 12) begin
                rtypes = {6'b0, 3'($urandom_range(0, 1) * 4), 3'($urandom_range(0, 1) * 4)};
                load(2, rtypes);
                pushed += 2;
            end else begin
                load(0, '0);
            end
            step();
            total += last_obs;
            guard++;
        end
        guard = 0;
        set_ready(2'b11, 1, 1); load(0, '0);
        while (mq.size() > 0 && guard < 60) begin
            step();
            total += last_obs;
            guard++;
        end
        load(0, '0); step();
        total += last_obs;
        chk("wrap.total_dispatched", 64'(total), 64'd40);

        // Flush with count=6 while 4 new ops arrive and 2 grants go out.
        set_ready(2'b00, 0, 0);
        load(4, {TA, TA, TA, TA}); step();
        load(2, {6'b0, TA, TA}); step();
        load(4, {TA, TA, TA, TA});
        flush = 1;
        set_ready(2'b11, 1, 1);
        #1;
        chk("flush.count_before", 64'(count), 64'd6);
        chk("flush.grants", 64'(alu_valid), 64'b11);
        step();
        flush = 0; load(0, '0);
        #1;
        chk("flush.count_after", 64'(count), 64'd0);
        chk("flush.valids_after", 64'({alu_valid, mem_valid, term_valid}), 64'd0);
        step();

        // Randomized traffic including terminators, wakeups, flushes, resets.
        for (int c = 0; c < 600; c++) begin
            rt = 3'($urandom_range(0, 7));
            rtypes = 12'($urandom);
            load($urandom_range(0, 4), rtypes);
            set_ready(2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            wakeup = ($urandom_range(0, 9) == 0);
            flush  = ($urandom_range(0, 49) == 0);
            rst    = (rt == 3'd0) && ($urandom_range(0, 19) == 0);
            step();
        end
        rst = 0; flush = 0; wakeup = 0;

`ifdef DISPATCH_STATS_EN
        // 10 dispatches and 3 stall cycles from a clean reset.
        rst = 1; load(0, '0); step(); rst = 0;
        set_ready(2'b00, 1, 1);
        load(4, {TA, TA, TA, TA}); step();
        load(4, {TA, TA, TA, TA}); step();
        load(2, {6'b0, TA, TA}); step();
        load(0, '0); step();
        set_ready(2'b11, 1, 1);
        for (int i = 0; i < 5; i++) step();
        #1;
        chk("stats.dispatched", 64'(stat_dispatched), 64'd10);
        chk("stats.stall", 64'(stat_stall), 64'd3);
        step();
        rst = 1; step(); rst = 0;
        #1;
        chk("stats.dispatched_rst", 64'(stat_dispatched), 64'd0);
        chk("stats.stall_rst", 64'(stat_stall), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
